// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: fetch-stage types, opcode constants and opcode classifier.
package riscv_fetch_pkg;
    localparam int FETCH_ADDR_W = 64;
    localparam int FETCH_ILEN   = 32;
    localparam int FETCH_TYPE_W = 3;

    localparam logic [2:0] R_TYPE       = 3'd0;
    localparam logic [2:0] I_TYPE       = 3'd1;
    localparam logic [2:0] S_TYPE       = 3'd2;
    localparam logic [2:0] SB_TYPE      = 3'd3;
    localparam logic [2:0] U_TYPE       = 3'd4;
    localparam logic [2:0] UJ_TYPE      = 3'd5;
    localparam logic [2:0] ILLEGAL_TYPE = 3'd7;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP_32  = 7'b0111011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fetch_state_t;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_ILEN-1:0]   instruction;
        logic [FETCH_TYPE_W-1:0] itype;
    } fetch_entry_t;

    function automatic logic [2:0] classify_opcode(input logic [6:0] op);
        case (op)
            OP_OP, OP_OP_32:                                     return R_TYPE;
            OP_LOAD, OP_IMM, OP_IMM_32, OP_JALR, OP_SYSTEM:      return I_TYPE;
            OP_STORE:                                            return S_TYPE;
            OP_BRANCH:                                           return SB_TYPE;
            OP_LUI, OP_AUIPC:                                    return U_TYPE;
            OP_JAL:                                              return UJ_TYPE;
            default:                                             return ILLEGAL_TYPE;
        endcase
    endfunction
endpackage

// File: rtl/instruction_fifo.sv
// instruction_fifo: entry buffer accepting 0/1/2 pushes and one pop per cycle, with flush.
module instruction_fifo import riscv_fetch_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     flush_i,
    input  logic [1:0]               push_n_i,
    input  fetch_entry_t             push0_i,
    input  fetch_entry_t             push1_i,
    input  logic                     pop_i,
    output fetch_entry_t             head_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  wp_q, rp_q;
    logic [CW-1:0]  count_q;
    logic           pop;

    assign pop     = pop_i && count_q != '0;
    assign head_o  = mem_q[rp_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_n_i != 2'd0) mem_q[wp_q] <= push0_i;
            if (push_n_i == 2'd2) mem_q[wp_q + PW'(1)] <= push1_i;
            wp_q    <= wp_q + PW'(push_n_i);
            rp_q    <= rp_q + PW'(pop);
            count_q <= count_q + CW'(push_n_i) - CW'(pop);
        end
    end

    // The upstream request gate must keep every push within the free slots.
    assert property (@(posedge clk_i) disable iff (!reset_n_i)
        flush_i || int'(push_n_i) + int'(count_q) <= DEPTH + int'(pop));
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: issues aligned two-instruction reads from PC, classifies and
// buffers instructions for decode; redirect flushes buffered and in-flight work.
module instruction_fetch_unit import riscv_fetch_pkg::*; #(
    parameter int ADDR_WIDTH         = FETCH_ADDR_W,
    parameter int BUS_DATA_WIDTH     = 64,
    parameter int INSTRUCTION_LENGTH = FETCH_ILEN,
    parameter int TYPE_WIDTH         = FETCH_TYPE_W,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [ADDR_WIDTH-1:0]         entry_i,
    output logic                          req_valid_o,
    output logic [ADDR_WIDTH-1:0]         req_addr_o,
    input  logic                          req_ready_i,
    input  logic                          resp_valid_i,
    input  logic [BUS_DATA_WIDTH-1:0]     resp_data_i,
    input  logic                          redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0]         redirect_pc_i,
    output logic                          instr_valid_o,
    input  logic                          instr_ready_i,
    output logic [INSTRUCTION_LENGTH-1:0] instruction_o,
    output logic [TYPE_WIDTH-1:0]         instruction_type_o,
    output logic [ADDR_WIDTH-1:0]         instr_pc_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d, aligned;
    logic [CW-1:0]          count;
    logic [1:0]             push_n;
    logic                   flush, pop;
    fetch_entry_t           lo, hi, head;

    assign aligned = {fetch_pc_q[ADDR_WIDTH-1:3], 3'b0};
    assign lo = '{pc: fetch_pc_q, instruction: resp_data_i[31:0],
                  itype: classify_opcode(resp_data_i[6:0])};
    assign hi = '{pc: aligned + ADDR_WIDTH'(4), instruction: resp_data_i[63:32],
                  itype: classify_opcode(resp_data_i[38:32])};

    // A beat is only requested when both of its instructions are guaranteed a slot.
    assign req_valid_o        = state_q == REQ && count <= CW'(FIFO_DEPTH - 2);
    assign req_addr_o         = aligned;
    assign flush              = redirect_valid_i && state_q != IDLE;
    assign pop                = instr_ready_i && !flush;
    assign instr_valid_o      = count != '0;
    assign instruction_o      = head.instruction;
    assign instruction_type_o = head.itype;
    assign instr_pc_o         = head.pc;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push_n     = 2'd0;
        case (state_q)
            IDLE: begin
                state_d    = REQ;
                fetch_pc_d = entry_i;
            end
            REQ: if (req_valid_o && req_ready_i) state_d = redirect_valid_i ? DROP : WAIT;
            WAIT: begin
                if (redirect_valid_i) state_d = resp_valid_i ? REQ : DROP;
                else if (resp_valid_i) begin
                    state_d    = REQ;
                    push_n     = fetch_pc_q[2] ? 2'd1 : 2'd2;
                    fetch_pc_d = aligned + ADDR_WIDTH'(8);
                end
            end
            default: if (resp_valid_i) state_d = REQ;
        endcase
        if (flush) fetch_pc_d = redirect_pc_i;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            fetch_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    instruction_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .flush_i  (flush),
        .push_n_i (push_n),
        .push0_i  (fetch_pc_q[2] ? hi : lo),
        .push1_i  (hi),
        .pop_i    (pop),
        .head_o   (head),
        .count_o  (count)
    );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed vector table plus hand sequences for backpressure,
// redirect and asynchronous reset.
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] entry;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [2:0]  instruction_type;
    logic [63:0] instr_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk_i             (clk),
        .reset_n_i         (reset_n),
        .entry_i           (entry),
        .req_valid_o       (req_valid),
        .req_addr_o        (req_addr),
        .req_ready_i       (req_ready),
        .resp_valid_i      (resp_valid),
        .resp_data_i       (resp_data),
        .redirect_valid_i  (redirect_valid),
        .redirect_pc_i     (redirect_pc),
        .instr_valid_o     (instr_valid),
        .instr_ready_i     (instr_ready),
        .instruction_o     (instruction),
        .instruction_type_o(instruction_type),
        .instr_pc_o        (instr_pc)
    );

    typedef struct {
        logic [63:0] entry;
        logic [63:0] data;
        int          n;
        logic [63:0] pc0;
        logic [31:0] i0;
        logic [2:0]  t0;
        logic [63:0] pc1;
        logic [31:0] i1;
        logic [2:0]  t1;
        logic [63:0] addr;
        logic [63:0] next;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [63:0] e);
        reset_n = 1'b0;
        req_ready = 1'b0;
        resp_valid = 1'b0;
        resp_data = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        entry = e;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_req(input string name, input logic [63:0] addr);
        int n = 0;
        while (!req_valid && n < 20) begin
            tick();
            n++;
        end
        chk({name, " req_valid"}, 64'(req_valid), 64'd1);
        chk({name, " req_addr"}, req_addr, addr);
    endtask

    task automatic fetch_beat(input string name, input logic [63:0] addr, input logic [63:0] data);
        wait_req(name, addr);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        resp_valid = 1'b1;
        resp_data = data;
        tick();
        resp_valid = 1'b0;
        chk({name, " instr_valid after beat"}, 64'(instr_valid), 64'd1);
    endtask

    task automatic pop_chk(input string name, input logic [63:0] pc, input logic [31:0] ins,
                           input logic [2:0] ty);
        chk({name, " head valid"}, 64'(instr_valid), 64'd1);
        chk({name, " instr_pc"}, instr_pc, pc);
        chk({name, " instruction"}, 64'(instruction), 64'(ins));
        chk({name, " type"}, 64'(instruction_type), 64'(ty));
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        chk({name, " req_valid"}, 64'(req_valid), 64'd0);
        chk({name, " req_addr"}, req_addr, 64'd0);
        chk({name, " instr_valid"}, 64'(instr_valid), 64'd0);
        chk({name, " instruction"}, 64'(instruction), 64'd0);
        chk({name, " type"}, 64'(instruction_type), 64'd0);
        chk({name, " instr_pc"}, instr_pc, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{64'h1000, 64'h00000013_00500093, 2, 64'h1000, 32'h00500093, 3'd1,
                    64'h1004, 32'h00000013, 3'd1, 64'h1000, 64'h1008};
        vecs[1] = '{64'h1004, 64'h00000013_00500093, 1, 64'h1004, 32'h00000013, 3'd1,
                    64'h0, 32'h0, 3'd0, 64'h1000, 64'h1008};
        vecs[2] = '{64'h3000, 64'h00000063_00000023, 2, 64'h3000, 32'h00000023, 3'd2,
                    64'h3004, 32'h00000063, 3'd3, 64'h3000, 64'h3008};
        vecs[3] = '{64'h4000, 64'h0000006F_00000037, 2, 64'h4000, 32'h00000037, 3'd4,
                    64'h4004, 32'h0000006F, 3'd5, 64'h4000, 64'h4008};
        vecs[4] = '{64'h5000, 64'h0000007F_00000033, 2, 64'h5000, 32'h00000033, 3'd0,
                    64'h5004, 32'h0000007F, 3'd7, 64'h5000, 64'h5008};
        vecs[5] = '{64'h6000, 64'h00000067_0000003B, 2, 64'h6000, 32'h0000003B, 3'd0,
                    64'h6004, 32'h00000067, 3'd1, 64'h6000, 64'h6008};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h00000017_00000073, 1, 64'hFFFF_FFFF_FFFF_FFFC,
                    32'h00000017, 3'd4, 64'h0, 32'h0, 3'd0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0};
        vecs[7] = '{64'h7000, 64'h0000001B_00000003, 2, 64'h7000, 32'h00000003, 3'd1,
                    64'h7004, 32'h0000001B, 3'd1, 64'h7000, 64'h7008};

        do_reset(64'h1000);
        reset_n = 1'b0;
        tick();
        chk_zero("reset");

        foreach (vecs[k]) begin
            string nm;
            nm = $sformatf("vec%0d", k);
            do_reset(vecs[k].entry);
            fetch_beat(nm, vecs[k].addr, vecs[k].data);
            chk({nm, " next req_addr"}, req_addr, vecs[k].next);
            pop_chk({nm, " e0"}, vecs[k].pc0, vecs[k].i0, vecs[k].t0);
            if (vecs[k].n == 2) pop_chk({nm, " e1"}, vecs[k].pc1, vecs[k].i1, vecs[k].t1);
            chk({nm, " drained"}, 64'(instr_valid), 64'd0);
        end

        do_reset(64'h1000);
        fetch_beat("bp1", 64'h1000, 64'h00000013_00500093);
        fetch_beat("bp2", 64'h1008, 64'h0000006F_00000037);
        chk("bp full req_valid", 64'(req_valid), 64'd0);
        tick();
        chk("bp full hold req_valid", 64'(req_valid), 64'd0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("bp count3 req_valid", 64'(req_valid), 64'd0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("bp count2 req_valid", 64'(req_valid), 64'd1);
        chk("bp count2 req_addr", req_addr, 64'h1010);
        chk("bp head pc", instr_pc, 64'h1008);

        do_reset(64'h1000);
        fetch_beat("rw", 64'h1000, 64'h00000013_00500093);
        wait_req("rw second", 64'h1008);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h2000;
        tick();
        redirect_valid = 1'b0;
        chk("rw flushed", 64'(instr_valid), 64'd0);
        chk("rw drop no req", 64'(req_valid), 64'd0);
        resp_valid = 1'b1;
        resp_data = 64'h0000006F_00000037;
        tick();
        resp_valid = 1'b0;
        chk("rw stale beat dropped", 64'(instr_valid), 64'd0);
        fetch_beat("rw new", 64'h2000, 64'h00000063_00000023);
        pop_chk("rw new e0", 64'h2000, 32'h00000023, 3'd2);
        pop_chk("rw new e1", 64'h2004, 32'h00000063, 3'd3);

        do_reset(64'h1000);
        wait_req("rc", 64'h1000);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        resp_valid = 1'b1;
        resp_data = 64'h00000013_00500093;
        redirect_valid = 1'b1;
        redirect_pc = 64'h3004;
        tick();
        resp_valid = 1'b0;
        redirect_valid = 1'b0;
        chk("rc beat dropped", 64'(instr_valid), 64'd0);
        chk("rc req_valid", 64'(req_valid), 64'd1);
        chk("rc req_addr", req_addr, 64'h3000);
        redirect_valid = 1'b1;
        redirect_pc = 64'h4008;
        tick();
        redirect_valid = 1'b0;
        chk("rr req_valid", 64'(req_valid), 64'd1);
        chk("rr req_addr switched", req_addr, 64'h4008);
        redirect_valid = 1'b1;
        redirect_pc = 64'h5000;
        req_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        req_ready = 1'b0;
        chk("ra drop no req", 64'(req_valid), 64'd0);
        resp_valid = 1'b1;
        resp_data = 64'h0000006F_00000037;
        tick();
        resp_valid = 1'b0;
        chk("ra old beat dropped", 64'(instr_valid), 64'd0);
        fetch_beat("ra new", 64'h5000, 64'h00000013_00500093);
        pop_chk("ra new e0", 64'h5000, 32'h00500093, 3'd1);

        do_reset(64'h1000);
        fetch_beat("mw", 64'h1000, 64'h00000013_00500093);
        wait_req("mw second", 64'h1008);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        chk("mw pre head pc", instr_pc, 64'h1000);
        reset_n = 1'b0;
        #1;
        chk_zero("midwait reset");
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
